// File: rtl/memory_pkg.sv
// Shared defaults for the memory_fifo codebase slice.
package memory_pkg;

    localparam int unsigned DEF_WORD      = 16;
    localparam int unsigned DEF_DEPTH     = 128;
    localparam int unsigned DEF_LOG_DEPTH = 7;
    localparam int unsigned DROP_CNT_W    = 16;

endpackage

// File: rtl/memory_fifo_if.sv
// Producer/consumer bundle for memory_fifo.
// Optional MEMORY_FIFO_DROP_CNT_EN adds the drop_cnt signal.
interface memory_fifo_if import memory_pkg::*; #(
    parameter int unsigned WORD      = DEF_WORD,
    parameter int unsigned LOG_DEPTH = DEF_LOG_DEPTH
);

    logic                 flush;
    logic                 wr_en;
    logic [WORD-1:0]      wr_data;
    logic                 full;
    logic                 almost_full;
    logic                 rd_valid;
    logic                 rd_ready;
    logic [WORD-1:0]      rd_data;
    logic [LOG_DEPTH:0]   count;
    logic                 overflow;
`ifdef MEMORY_FIFO_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt;

    modport master (
        output flush, wr_en, wr_data, rd_ready,
        input  full, almost_full, rd_valid, rd_data, count, overflow, drop_cnt
    );
    modport slave (
        input  flush, wr_en, wr_data, rd_ready,
        output full, almost_full, rd_valid, rd_data, count, overflow, drop_cnt
    );
`else
    modport master (
        output flush, wr_en, wr_data, rd_ready,
        input  full, almost_full, rd_valid, rd_data, count, overflow
    );
    modport slave (
        input  flush, wr_en, wr_data, rd_ready,
        output full, almost_full, rd_valid, rd_data, count, overflow
    );
`endif

endinterface

// File: rtl/memory_fifo_ram.sv
// Simple dual-port array; the registered read port doubles as the FIFO output stage.
module memory_fifo_ram import memory_pkg::*; #(
    parameter int unsigned WORD      = DEF_WORD,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned LOG_DEPTH = DEF_LOG_DEPTH
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 wr_en,
    input  logic [LOG_DEPTH-1:0] wr_addr,
    input  logic [WORD-1:0]      wr_data,
    input  logic                 rd_en,
    input  logic [LOG_DEPTH-1:0] rd_addr,
    output logic [WORD-1:0]      rd_data
);

    logic [WORD-1:0] mem [DEPTH];

    // Synchronous write; storage is never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register: loads only on read-enable, otherwise holds the head word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/memory_fifo.sv
// Circular-buffer FIFO: push-only write side, valid/ready read side.
// Optional MEMORY_FIFO_DROP_CNT_EN adds a saturating dropped-push counter.
module memory_fifo import memory_pkg::*; #(
    parameter int unsigned WORD      = DEF_WORD,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned LOG_DEPTH = DEF_LOG_DEPTH,
    parameter int unsigned AF_LEVEL  = DEPTH - 4
) (
    input  logic          clk,
    input  logic          rstn,
    memory_fifo_if.slave  bus
);

    localparam logic [LOG_DEPTH:0]   DEPTH_C = (LOG_DEPTH+1)'(DEPTH);
    localparam logic [LOG_DEPTH:0]   AF_C    = (LOG_DEPTH+1)'(AF_LEVEL);
    localparam logic [LOG_DEPTH:0]   CNT_ONE = (LOG_DEPTH+1)'(1);
    localparam logic [LOG_DEPTH-1:0] PTR_ONE = LOG_DEPTH'(1);

    logic [LOG_DEPTH-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [LOG_DEPTH:0]   count_q, count_d, arr_cnt;
    logic                 rd_valid_q, rd_valid_d;
    logic                 overflow_q, overflow_d;
    logic                 full, push, drop, pop, load;

    // Handshake decode; flush masks every request in its cycle.
    always_comb begin
        full    = (count_q == DEPTH_C);
        // Words still in the array, i.e. excluding the output stage.
        arr_cnt = count_q - {{LOG_DEPTH{1'b0}}, rd_valid_q};
        push    = bus.wr_en && !full && !bus.flush;
        drop    = bus.wr_en && full && !bus.flush;
        pop     = rd_valid_q && bus.rd_ready && !bus.flush;
        load    = (arr_cnt != '0) && (!rd_valid_q || pop) && !bus.flush;
    end

    // Next-state for pointers, occupancy and flags.
    always_comb begin
        wp_d       = wp_q;
        rp_d       = rp_q;
        count_d    = count_q;
        rd_valid_d = rd_valid_q;
        overflow_d = overflow_q;
        if (bus.flush) begin
            wp_d       = '0;
            rp_d       = '0;
            count_d    = '0;
            rd_valid_d = 1'b0;
            overflow_d = 1'b0;
        end else begin
            if (push) wp_d = wp_q + PTR_ONE;
            if (load) rp_d = rp_q + PTR_ONE;
            if (drop) overflow_d = 1'b1;
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
            if (load) begin
                rd_valid_d = 1'b1;
            end else if (pop) begin
                rd_valid_d = 1'b0;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef MEMORY_FIFO_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of dropped pushes.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (bus.flush) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    // Drop counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`endif

    assign bus.full        = full;
    assign bus.almost_full = (count_q >= AF_C);
    assign bus.rd_valid    = rd_valid_q;
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;

    memory_fifo_ram #(
        .WORD      (WORD),
        .DEPTH     (DEPTH),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_ram (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (push),
        .wr_addr (wp_q),
        .wr_data (bus.wr_data),
        .rd_en   (load),
        .rd_addr (rp_q),
        .rd_data (bus.rd_data)
    );

endmodule
